ps_mem_host: RTL and testbench

- Synthesizable counterpart to the 16-bit pipelined processor's memory interfaces. It is the responder on the IM read port and the DM read/write port.
- Also acts as host-side run controller:
  - preloads IM/DM
  - pulses start
  - waits for stop or timeout
  - exposes DM for readback
- Sits beside pipelinedPS in FPGA/top-level integration, replacing the bench-only memory models.

---
 rtl/ps_mem_host_if.sv | 47 ++++
 rtl/ps_mem_host.sv | 190 +++++++++++++++++++
 tb/tb_ps_mem_host.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps_mem_host_if.sv
// Processor memory ports, host access port and run-control signals
// shared between ps_mem_host and whatever drives it.
interface ps_mem_host_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 24
);
    logic [ADDR_WIDTH-1:0] im_addr;
    logic                  im_rd;
    logic [DATA_WIDTH-1:0] im_r_data;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic                  dm_rd;
    logic                  dm_wr;
    logic [DATA_WIDTH-1:0] dm_w_data;
    logic [DATA_WIDTH-1:0] dm_r_data;
    logic                  start;
    logic                  stop;
    logic                  host_we;
    logic                  host_rd;
    logic                  host_sel;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic [DATA_WIDTH-1:0] host_rdata;
    logic                  go;
    logic                  clear;
    logic                  busy;
    logic                  done;
    logic                  timeout;
    logic                  host_err;
    logic [CNT_WIDTH-1:0]  run_cycles;

    modport slave (
        input  im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data,
        input  stop, host_we, host_rd, host_sel, host_addr, host_wdata,
        input  go, clear,
        output im_r_data, dm_r_data, start, host_rdata,
        output busy, done, timeout, host_err, run_cycles
    );

    modport master (
        output im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data,
        output stop, host_we, host_rd, host_sel, host_addr, host_wdata,
        output go, clear,
        input  im_r_data, dm_r_data, start, host_rdata,
        input  busy, done, timeout, host_err, run_cycles
    );
endinterface

// File: rtl/ps_mem_host.sv
// IM/DM responder and host run controller for the pipelined processor.
// Define DM_WRITE_FWD_EN to forward same-cycle DM write data to a DM read.
module ps_mem_host #(
    parameter int                   ADDR_WIDTH = 8,
    parameter int                   DATA_WIDTH = 16,
    parameter int                   IM_DEPTH   = 256,
    parameter int                   DM_DEPTH   = 256,
    parameter int                   CNT_WIDTH  = 24,
    parameter logic [CNT_WIDTH-1:0] MAX_CYCLES = 24'd500000
) (
    input  logic             clk,
    input  logic             rst,
    ps_mem_host_if.slave     bus
);

    localparam int IM_AW = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
    localparam int DM_AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATA_WIDTH-1:0] im_mem [IM_DEPTH];
    logic [DATA_WIDTH-1:0] dm_mem [DM_DEPTH];

    logic                  start_c;
    logic                  busy_c;
    logic                  done_c;
    logic                  timeout_c;
    logic                  host_ok;
    logic                  host_hit;
    logic                  im_ok;
    logic                  dm_ok;
    logic                  hi_ok;
    logic                  hd_ok;
    logic [IM_AW-1:0]      im_idx;
    logic [DM_AW-1:0]      dm_idx;
    logic [IM_AW-1:0]      hi_idx;
    logic [DM_AW-1:0]      hd_idx;
    logic [DATA_WIDTH-1:0] dm_rd_val;
    logic [DATA_WIDTH-1:0] host_rd_val;
    logic [DATA_WIDTH-1:0] im_r_q;
    logic [DATA_WIDTH-1:0] dm_r_q;
    logic [DATA_WIDTH-1:0] host_r_q;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  cyc_q;

    assign im_idx = bus.im_addr[IM_AW-1:0];
    assign dm_idx = bus.dm_addr[DM_AW-1:0];
    assign hi_idx = bus.host_addr[IM_AW-1:0];
    assign hd_idx = bus.host_addr[DM_AW-1:0];

    // A memory that covers the whole address space needs no range check
    generate
        if (IM_DEPTH >= 2 ** ADDR_WIDTH) begin : g_im_full
            assign im_ok = 1'b1;
            assign hi_ok = 1'b1;
        end else begin : g_im_part
            assign im_ok = 32'(bus.im_addr) < 32'(IM_DEPTH);
            assign hi_ok = 32'(bus.host_addr) < 32'(IM_DEPTH);
        end
        if (DM_DEPTH >= 2 ** ADDR_WIDTH) begin : g_dm_full
            assign dm_ok = 1'b1;
            assign hd_ok = 1'b1;
        end else begin : g_dm_part
            assign dm_ok = 32'(bus.dm_addr) < 32'(DM_DEPTH);
            assign hd_ok = 32'(bus.host_addr) < 32'(DM_DEPTH);
        end
    endgenerate

    assign host_ok  = (state == S_IDLE) || (state == S_DONE) ||
                      (state == S_TIMEOUT);
    assign host_hit = bus.host_we || bus.host_rd;

`ifdef DM_WRITE_FWD_EN
    assign dm_rd_val = !dm_ok     ? '0 :
                       bus.dm_wr  ? bus.dm_w_data :
                                    dm_mem[dm_idx];
`else
    assign dm_rd_val = dm_ok ? dm_mem[dm_idx] : '0;
`endif

    always_comb begin
        host_rd_val = '0;
        if (bus.host_sel) begin
            if (hd_ok) host_rd_val = dm_mem[hd_idx];
        end else begin
            if (hi_ok) host_rd_val = im_mem[hi_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        start_c   = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        timeout_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.go) state_nx = S_START;
            end
            S_START: begin
                start_c  = 1'b1;
                busy_c   = 1'b1;
                state_nx = S_RUN;
            end
            S_RUN: begin
                busy_c = 1'b1;
                if (bus.stop)         state_nx = S_DONE;
                else if (cyc_q == LAST) state_nx = S_TIMEOUT;
            end
            S_DONE: begin
                done_c = 1'b1;
                if (bus.go)         state_nx = S_START;
                else if (bus.clear) state_nx = S_IDLE;
            end
            S_TIMEOUT: begin
                timeout_c = 1'b1;
                if (bus.go)         state_nx = S_START;
                else if (bus.clear) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Storage has no reset; contents survive a mid-run reset
    always_ff @(posedge clk) begin
        if (bus.dm_wr && dm_ok)
            dm_mem[dm_idx] <= bus.dm_w_data;
        if (host_ok && bus.host_we && bus.host_sel && hd_ok)
            dm_mem[hd_idx] <= bus.host_wdata;
        if (host_ok && bus.host_we && !bus.host_sel && hi_ok)
            im_mem[hi_idx] <= bus.host_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            im_r_q   <= '0;
            dm_r_q   <= '0;
            host_r_q <= '0;
        end else begin
            if (bus.im_rd)
                im_r_q <= im_ok ? im_mem[im_idx] : '0;
            if (bus.dm_rd)
                dm_r_q <= dm_rd_val;
            if (host_ok && bus.host_rd)
                host_r_q <= host_rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
            cyc_q <= '0;
        end else begin
            if (state == S_IDLE && bus.go)
                err_q <= 1'b0;
            else if (!host_ok && host_hit)
                err_q <= 1'b1;
            if (state == S_START)
                cyc_q <= '0;
            else if (state == S_RUN)
                cyc_q <= cyc_q + 1'b1;
        end
    end

    assign bus.im_r_data  = im_r_q;
    assign bus.dm_r_data  = dm_r_q;
    assign bus.host_rdata = host_r_q;
    assign bus.start      = start_c;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.timeout    = timeout_c;
    assign bus.host_err   = err_q;
    assign bus.run_cycles = cyc_q;

endmodule

// File: tb/tb_ps_mem_host.sv
// Bench for ps_mem_host: cycle model of the memories and run controller
// compared every cycle, plus directed literal checks.
module tb_ps_mem_host;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CW = 24;
    localparam logic [CW-1:0] MAXC = 24'd100;

`ifdef DM_WRITE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_START = 1;
    localparam int P_RUN   = 2;
    localparam int P_DONE  = 3;
    localparam int P_TO    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps_mem_host_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();

    ps_mem_host #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IM_DEPTH(256), .DM_DEPTH(256),
        .CNT_WIDTH(CW), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int steps = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: what each output must hold after every posedge
    int              m_phase = P_IDLE;
    bit              m_ok = 1'b0;
    logic [CW-1:0]   m_rc;
    logic            m_err;
    logic [DW-1:0]   m_im, m_dm, m_hr;
    logic [DW-1:0]   im_m [256];
    logic [DW-1:0]   dm_m [256];

    function automatic bit host_window(input int ph);
        return ph == P_IDLE || ph == P_DONE || ph == P_TO;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_phase <= P_IDLE;
            m_rc    <= '0;
            m_err   <= 1'b0;
            m_im    <= '0;
            m_dm    <= '0;
            m_hr    <= '0;
            m_ok    <= 1'b1;
        end else begin
            if (bus.im_rd) m_im <= im_m[bus.im_addr];
            if (bus.dm_rd)
                m_dm <= (FWD && bus.dm_wr) ? bus.dm_w_data : dm_m[bus.dm_addr];
            if (bus.dm_wr) dm_m[bus.dm_addr] <= bus.dm_w_data;
            if (host_window(m_phase)) begin
                if (bus.host_rd)
                    m_hr <= bus.host_sel ? dm_m[bus.host_addr]
                                         : im_m[bus.host_addr];
                if (bus.host_we && bus.host_sel)
                    dm_m[bus.host_addr] <= bus.host_wdata;
                if (bus.host_we && !bus.host_sel)
                    im_m[bus.host_addr] <= bus.host_wdata;
            end else if (bus.host_we || bus.host_rd) begin
                m_err <= 1'b1;
            end
            if (m_phase == P_IDLE) begin
                if (bus.go) begin
                    m_phase <= P_START;
                    m_err   <= 1'b0;
                end
            end else if (m_phase == P_START) begin
                m_phase <= P_RUN;
                m_rc    <= '0;
            end else if (m_phase == P_RUN) begin
                m_rc <= m_rc + 1;
                if (bus.stop)               m_phase <= P_DONE;
                else if (m_rc + 1 == MAXC)  m_phase <= P_TO;
            end else begin
                if (bus.go)         m_phase <= P_START;
                else if (bus.clear) m_phase <= P_IDLE;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("start",      bus.start,      32'(m_phase == P_START));
            chk("busy",       bus.busy,
                32'(m_phase == P_START || m_phase == P_RUN));
            chk("done",       bus.done,       32'(m_phase == P_DONE));
            chk("timeout",    bus.timeout,    32'(m_phase == P_TO));
            chk("host_err",   bus.host_err,   32'(m_err));
            chk("run_cycles", bus.run_cycles, 32'(m_rc));
            chk("im_r_data",  bus.im_r_data,  32'(m_im));
            chk("dm_r_data",  bus.dm_r_data,  32'(m_dm));
            chk("host_rdata", bus.host_rdata, 32'(m_hr));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        steps++;
    endtask

    task automatic hwr(input bit sel, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        bus.host_we    = 1'b1;
        bus.host_sel   = sel;
        bus.host_addr  = a;
        bus.host_wdata = d;
        step();
        bus.host_we    = 1'b0;
    endtask

    task automatic hrd(input bit sel, input logic [AW-1:0] a);
        bus.host_rd   = 1'b1;
        bus.host_sel  = sel;
        bus.host_addr = a;
        step();
        bus.host_rd   = 1'b0;
    endtask

    initial begin
        bus.im_addr = '0; bus.im_rd = 1'b0;
        bus.dm_addr = '0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
        bus.dm_w_data = '0; bus.stop = 1'b0;
        bus.host_we = 1'b0; bus.host_rd = 1'b0; bus.host_sel = 1'b0;
        bus.host_addr = '0; bus.host_wdata = '0;
        bus.go = 1'b0; bus.clear = 1'b0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_cycles", bus.run_cycles, 0);
        chk("rst_hrdata", bus.host_rdata, 0);

        hwr(0, 8'd0, 16'h1234);
        hwr(0, 8'd1, 16'h5678);
        hwr(0, 8'd2, 16'h9ABC);
        hwr(0, 8'd3, 16'hDEF0);
        hwr(1, 8'd0, 16'h0007);
        hwr(1, 8'd3, 16'h3333);
        hwr(1, 8'd5, 16'h0001);
        hwr(1, 8'd12, 16'h0000);
        hrd(0, 8'd2);
        chk("host_im2", bus.host_rdata, 16'h9ABC);

        bus.go = 1'b1;
        steps = 0;
        step();
        bus.go = 1'b0;
        chk("start_hi", bus.start, 1);
        chk("busy_hi", bus.busy, 1);
        bus.im_rd = 1'b1;
        bus.im_addr = 8'd2;
        step();
        bus.im_rd = 1'b0;
        chk("start_1cyc", bus.start, 0);
        chk("im2_read", bus.im_r_data, 16'h9ABC);

        bus.dm_wr = 1'b1; bus.dm_addr = 8'd12; bus.dm_w_data = 16'd7;
        step();
        bus.dm_wr = 1'b0; bus.dm_rd = 1'b1;
        step();
        bus.dm_rd = 1'b0;
        chk("dm12_read", bus.dm_r_data, 16'd7);

        bus.dm_rd = 1'b1; bus.dm_wr = 1'b1;
        bus.dm_addr = 8'd5; bus.dm_w_data = 16'h00AA;
        step();
        bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
        chk("dm5_collide", bus.dm_r_data, FWD ? 16'h00AA : 16'h0001);

        hwr(1, 8'd3, 16'hFFFF);
        chk("err_set", bus.host_err, 1);

        while (steps < 41) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("done_hi", bus.done, 1);
        chk("cycles_40", bus.run_cycles, 40);
        chk("err_sticky", bus.host_err, 1);
        hrd(1, 8'd12);
        chk("host_dm12", bus.host_rdata, 16'd7);
        hrd(1, 8'd3);
        chk("host_dm3", bus.host_rdata, 16'h3333);

        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_start", bus.start, 0);
        chk("midrst_err", bus.host_err, 0);
        hrd(0, 8'd0);
        chk("midrst_im0", bus.host_rdata, 16'h1234);

        bus.go = 1'b1;
        steps = 0;
        step();
        bus.go = 1'b0;
        hrd(0, 8'd1);
        while (steps < 101) step();
        chk("to_not_yet", bus.timeout, 0);
        step();
        chk("to_hi", bus.timeout, 1);
        chk("to_cycles", bus.run_cycles, 100);
        chk("to_err", bus.host_err, 1);

        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clr_idle", bus.timeout, 0);
        chk("clr_hold", bus.run_cycles, 100);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        chk("relaunch", bus.start, 1);
        chk("relaunch_err", bus.host_err, 0);
        step();
        chk("relaunch_rc", bus.run_cycles, 0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("short_run", bus.run_cycles, 1);
        bus.go = 1'b1; bus.clear = 1'b1;
        step();
        bus.go = 1'b0; bus.clear = 1'b0;
        chk("go_over_clr", bus.start, 1);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
